deal_arbiter: RTL and testbench

Shares the single card-dealing LUT (pip strobe in, 4-bit number out) between the player hand and the dealer hand. It arbitrates draw requests, sequences the pip/capture handshake with the LUT, and keeps per-hand bookkeeping: card count, total in half-points, bust and full flags. It sits between the game FSM (requester side) and the LUT instance, so the game FSM no longer drives pip or latches number directly.

---
 rtl/tenthirty_pkg.sv | 27 ++
 rtl/hand_acc.sv | 54 +++++
 rtl/deal_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_deal_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tenthirty_pkg.sv
// tenthirty_pkg: shared types and constants for the ten-and-a-half game.
//   state_e   : arbiter FSM states
//   MAX_CARDS : cards per hand, BUST_HALF : bust threshold in half-points
//   CARD_MIN/CARD_MAX : legal LUT output range, FACE_MIN : first face card
//   half_pts(card) : value of one card in half-points (face cards = 1)
package tenthirty_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  localparam int MAX_CARDS = 5;
  localparam int BUST_HALF = 21;
  localparam int CARD_MIN  = 1;
  localparam int CARD_MAX  = 13;
  localparam int FACE_MIN  = 11;

  // Pip cards count their face value in whole points, face cards half a point.
  function automatic logic [4:0] half_pts(input logic [3:0] card);
    if (card >= 4'(FACE_MIN)) return 5'd1;
    else                      return {card, 1'b0};
  endfunction

endpackage

// File: rtl/hand_acc.sv
// hand_acc: per-hand bookkeeping.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous wipe (priority over add)
//   add, pts   : one-cycle strobe adding a card worth pts half-points
//   cnt, tot   : registered card count and total (half-points)
//   bust, full : tot > BUST_HALF, cnt == MAX_CARDS
module hand_acc
  import tenthirty_pkg::*;
#(
  parameter int MAX_CARDS = tenthirty_pkg::MAX_CARDS,
  parameter int BUST_HALF = tenthirty_pkg::BUST_HALF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       add,
  input  logic [4:0] pts,
  output logic [2:0] cnt,
  output logic [6:0] tot,
  output logic       bust,
  output logic       full
);

  logic [2:0] cnt_q, cnt_d;
  logic [6:0] tot_q, tot_d;

  always_comb begin
    cnt_d = cnt_q;
    tot_d = tot_q;
    if (clr) begin
      cnt_d = '0;
      tot_d = '0;
    end else if (add) begin
      cnt_d = cnt_q + 3'd1;
      tot_d = tot_q + {2'b00, pts};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tot_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tot_q <= tot_d;
    end
  end

  assign cnt  = cnt_q;
  assign tot  = tot_q;
  assign bust = tot_q > 7'(BUST_HALF);
  assign full = cnt_q == 3'(MAX_CARDS);

endmodule

// File: rtl/deal_arbiter.sv
// deal_arbiter: shares the card LUT between player and dealer hands.
//   clk, rst_n     : clock, async active-low reset
//   clr            : synchronous round clear (highest priority)
//   req_p, req_d   : level draw requests
//   pip / number   : strobe to the LUT and its 4-bit card answer
//   gnt_p, gnt_d   : one-cycle grant pulses; card/slot describe that card
//   cnt_*, tot_*, bust_*, full_* : per-hand bookkeeping
//   busy           : FSM not idle;  err : sticky LUT failure flag
module deal_arbiter
  import tenthirty_pkg::*;
#(
  parameter int LUT_LAT   = 1,
  parameter int MAX_RETRY = 3,
  parameter int MAX_CARDS = tenthirty_pkg::MAX_CARDS,
  parameter int BUST_HALF = tenthirty_pkg::BUST_HALF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       req_p,
  input  logic       req_d,
  output logic       pip,
  input  logic [3:0] number,
  output logic       gnt_p,
  output logic       gnt_d,
  output logic [3:0] card,
  output logic [2:0] slot,
  output logic [2:0] cnt_p,
  output logic [2:0] cnt_d,
  output logic [6:0] tot_p,
  output logic [6:0] tot_d,
  output logic       bust_p,
  output logic       bust_d,
  output logic       full_p,
  output logic       full_d,
  output logic       busy,
  output logic       err
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_e        state_q, state_d;
  logic          sel_q, sel_d;      // hand being served: 0 player, 1 dealer
  logic          prio_q, prio_d;    // hand that wins the next tie
  logic [2:0]    wait_q, wait_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          err_q, err_d;
  logic          gnt_p_q, gnt_p_d;
  logic          gnt_d_q, gnt_d_d;
  logic [3:0]    card_q, card_d;
  logic [2:0]    slot_q, slot_d;

  logic elig_p, elig_d, num_ok, cap_ok;

  assign elig_p = req_p & ~full_p & ~bust_p;
  assign elig_d = req_d & ~full_d & ~bust_d;
  assign num_ok = (number >= 4'(CARD_MIN)) && (number <= 4'(CARD_MAX));
  assign cap_ok = (state_q == S_CAPTURE) && num_ok && !clr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (elig_p || elig_d) state_d = S_ISSUE;
        S_ISSUE:   state_d = (LUT_LAT <= 1) ? S_CAPTURE : S_WAIT;
        S_WAIT:    if (wait_q == 3'(LUT_LAT - 1)) state_d = S_CAPTURE;
        S_CAPTURE: begin
          if (num_ok)                          state_d = S_IDLE;
          else if (retry_q < RW'(MAX_RETRY))   state_d = S_ISSUE;
          else                                 state_d = S_IDLE;
        end
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; a clear in the ISSUE cycle suppresses the strobe.
  always_comb begin
    pip  = (state_q == S_ISSUE) && !clr;
    busy = (state_q != S_IDLE);
  end

  // Datapath next values
  always_comb begin
    sel_d   = sel_q;
    prio_d  = prio_q;
    wait_d  = wait_q;
    retry_d = retry_q;
    err_d   = err_q;
    card_d  = card_q;
    slot_d  = slot_q;
    gnt_p_d = 1'b0;
    gnt_d_d = 1'b0;
    if (clr) begin
      // Round clear wipes everything except the tie-break pointer.
      wait_d  = '0;
      retry_d = '0;
      err_d   = 1'b0;
      card_d  = '0;
      slot_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (elig_p && elig_d) sel_d = prio_q;
          else if (elig_p)      sel_d = 1'b0;
          else if (elig_d)      sel_d = 1'b1;
        end
        // wait_q numbers the WAIT cycles starting at 1, so LUT_LAT-1 is the last.
        S_ISSUE: wait_d = 3'd1;
        S_WAIT:  wait_d = wait_q + 3'd1;
        S_CAPTURE: begin
          if (num_ok) begin
            card_d  = number;
            slot_d  = sel_q ? cnt_d : cnt_p;
            gnt_p_d = ~sel_q;
            gnt_d_d = sel_q;
            retry_d = '0;
            prio_d  = ~prio_q;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
          end else begin
            err_d   = 1'b1;
            retry_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      wait_q  <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      card_q  <= '0;
      slot_q  <= '0;
      gnt_p_q <= 1'b0;
      gnt_d_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      wait_q  <= wait_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      card_q  <= card_d;
      slot_q  <= slot_d;
      gnt_p_q <= gnt_p_d;
      gnt_d_q <= gnt_d_d;
    end
  end

  assign gnt_p = gnt_p_q;
  assign gnt_d = gnt_d_q;
  assign card  = card_q;
  assign slot  = slot_q;
  assign err   = err_q;

  hand_acc #(.MAX_CARDS(MAX_CARDS), .BUST_HALF(BUST_HALF)) u_hand_p (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .add(cap_ok & ~sel_q), .pts(half_pts(number)),
    .cnt(cnt_p), .tot(tot_p), .bust(bust_p), .full(full_p)
  );

  hand_acc #(.MAX_CARDS(MAX_CARDS), .BUST_HALF(BUST_HALF)) u_hand_d (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .add(cap_ok & sel_q), .pts(half_pts(number)),
    .cnt(cnt_d), .tot(tot_d), .bust(bust_d), .full(full_d)
  );

endmodule

// File: tb/tb_deal_arbiter.sv
// tb_deal_arbiter: two arbiters (LUT latency 1 and 3) driven by directed and
// random draws; a hand-level model predicts winner, latency, card, totals.
module tb_deal_arbiter;

  localparam int MAXR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       clr_i[2], rp_i[2], rd_i[2];
  logic [3:0] num_i[2];
  logic       pip_o[2], gp_o[2], gd_o[2], busy_o[2], err_o[2];
  logic       bp_o[2], bd_o[2], fp_o[2], fd_o[2];
  logic [3:0] card_o[2];
  logic [2:0] slot_o[2], cp_o[2], cd_o[2];
  logic [6:0] tp_o[2], td_o[2];

  deal_arbiter #(.LUT_LAT(1), .MAX_RETRY(MAXR)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_i[0]), .req_p(rp_i[0]), .req_d(rd_i[0]),
    .pip(pip_o[0]), .number(num_i[0]), .gnt_p(gp_o[0]), .gnt_d(gd_o[0]),
    .card(card_o[0]), .slot(slot_o[0]), .cnt_p(cp_o[0]), .cnt_d(cd_o[0]),
    .tot_p(tp_o[0]), .tot_d(td_o[0]), .bust_p(bp_o[0]), .bust_d(bd_o[0]),
    .full_p(fp_o[0]), .full_d(fd_o[0]), .busy(busy_o[0]), .err(err_o[0]));

  deal_arbiter #(.LUT_LAT(3), .MAX_RETRY(MAXR)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_i[1]), .req_p(rp_i[1]), .req_d(rd_i[1]),
    .pip(pip_o[1]), .number(num_i[1]), .gnt_p(gp_o[1]), .gnt_d(gd_o[1]),
    .card(card_o[1]), .slot(slot_o[1]), .cnt_p(cp_o[1]), .cnt_d(cd_o[1]),
    .tot_p(tp_o[1]), .tot_d(td_o[1]), .bust_p(bp_o[1]), .bust_d(bd_o[1]),
    .full_p(fp_o[1]), .full_d(fd_o[1]), .busy(busy_o[1]), .err(err_o[1]));

  // Event monitors: pip and grant counts, back-to-back pip detection.
  int   pipcnt[2] = '{0, 0};
  int   gntcnt[2] = '{0, 0};
  bit   dblpip[2] = '{1'b0, 1'b0};
  logic pprev[2]  = '{1'b0, 1'b0};
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pip_o[i] === 1'b1) pipcnt[i] <= pipcnt[i] + 1;
      if (pip_o[i] === 1'b1 && pprev[i] === 1'b1) dblpip[i] <= 1'b1;
      pprev[i] <= pip_o[i];
      if (gp_o[i] === 1'b1 || gd_o[i] === 1'b1) gntcnt[i] <= gntcnt[i] + 1;
    end
  end

  // Hand-level model: [inst][0=player,1=dealer]
  int m_cnt[2][2];
  int m_tot[2][2];
  bit m_prio[2];   // side that wins the next tie
  bit m_err[2];
  int lat[2] = '{1, 3};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_hands(input int i);
    chk("cnt_p", cp_o[i], m_cnt[i][0]);
    chk("cnt_d", cd_o[i], m_cnt[i][1]);
    chk("tot_p", tp_o[i], m_tot[i][0]);
    chk("tot_d", td_o[i], m_tot[i][1]);
    chk("bust_p", bp_o[i], m_tot[i][0] > 21);
    chk("bust_d", bd_o[i], m_tot[i][1] > 21);
    chk("full_p", fp_o[i], m_cnt[i][0] == 5);
    chk("full_d", fd_o[i], m_cnt[i][1] == 5);
    chk("err", err_o[i], m_err[i]);
  endtask

  function automatic bit can_draw(input int i, input int s);
    return m_cnt[i][s] < 5 && m_tot[i][s] <= 21;
  endfunction

  // One draw attempt: raise the requests, follow it to grant / error / nothing.
  task automatic draw(input int i, input bit rp, input bit rd, input logic [3:0] v);
    bit ep, ed;
    int side, k, p0, g0;
    ep = rp && can_draw(i, 0);
    ed = rd && can_draw(i, 1);
    @(negedge clk);
    num_i[i] = v; rp_i[i] = rp; rd_i[i] = rd;
    p0 = pipcnt[i]; g0 = gntcnt[i];
    if (!ep && !ed) begin
      repeat (lat[i] + 4) begin
        @(negedge clk);
        chk("ignored_busy", busy_o[i], 0);
      end
      rp_i[i] = 1'b0; rd_i[i] = 1'b0;
      chk("ignored_pip", pipcnt[i] - p0, 0);
      chk("ignored_gnt", gntcnt[i] - g0, 0);
      return;
    end
    side = (ep && ed) ? int'(m_prio[i]) : (ep ? 0 : 1);
    k = 0;
    if (v >= 1 && v <= 13) begin
      do begin @(negedge clk); k++; end
      while (gp_o[i] !== 1'b1 && gd_o[i] !== 1'b1 && k < 40);
      rp_i[i] = 1'b0; rd_i[i] = 1'b0;
      chk("latency", k, lat[i] + 2);
      chk("gnt_p", gp_o[i], side == 0);
      chk("gnt_d", gd_o[i], side == 1);
      chk("card", card_o[i], v);
      chk("slot", slot_o[i], m_cnt[i][side]);
      chk("pips", pipcnt[i] - p0, 1);
      m_cnt[i][side] += 1;
      m_tot[i][side] += (v >= 11) ? 1 : 2 * int'(v);
      m_prio[i] = !m_prio[i];
    end else begin
      do begin @(negedge clk); k++; end
      while (busy_o[i] !== 1'b0 && k < 100);
      rp_i[i] = 1'b0; rd_i[i] = 1'b0;
      chk("err_latency", k, (MAXR + 1) * (lat[i] + 1) + 1);
      chk("err_pips", pipcnt[i] - p0, MAXR + 1);
      chk("err_gnt", gntcnt[i] - g0, 0);
      m_err[i] = 1'b1;
    end
    @(negedge clk);
    check_hands(i);
  endtask

  task automatic do_clr(input int i);
    @(negedge clk); clr_i[i] = 1'b1;
    @(negedge clk); clr_i[i] = 1'b0;
    for (int s = 0; s < 2; s++) begin m_cnt[i][s] = 0; m_tot[i][s] = 0; end
    m_err[i] = 1'b0;
    check_hands(i);
    chk("clr_card", card_o[i], 0);
    chk("clr_slot", slot_o[i], 0);
    chk("clr_busy", busy_o[i], 0);
  endtask

  initial begin
    int p0, g0, r;
    bit rp, rd;
    logic [3:0] v;
    for (int i = 0; i < 2; i++) begin
      clr_i[i] = 1'b0; rp_i[i] = 1'b0; rd_i[i] = 1'b0; num_i[i] = 4'd0;
      m_prio[i] = 1'b0; m_err[i] = 1'b0;
      for (int s = 0; s < 2; s++) begin m_cnt[i][s] = 0; m_tot[i][s] = 0; end
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_hands(i);
      chk("rst_pip", pip_o[i], 0);
      chk("rst_gnt", {gp_o[i], gd_o[i]}, 0);
      chk("rst_card", card_o[i], 0);
      chk("rst_slot", slot_o[i], 0);
      chk("rst_busy", busy_o[i], 0);
    end
    rst_n = 1'b1;

    // Both requesting from reset: player, dealer, player, dealer.
    for (int i = 0; i < 2; i++) begin
      draw(i, 1, 1, 4'd3);
      draw(i, 1, 1, 4'd12);
      draw(i, 1, 1, 4'd8);
      draw(i, 1, 1, 4'd1);
      do_clr(i);
    end

    // Single player draw of a 7.
    draw(0, 1, 0, 4'd7);
    do_clr(0);

    // Player 10 + 12 = 21 (no bust), then 1 busts; further request ignored.
    draw(0, 1, 0, 4'd10);
    draw(0, 1, 0, 4'd12);
    draw(0, 1, 0, 4'd1);
    draw(0, 1, 0, 4'd5);

    // Dealer takes five face cards, sixth request ignored.
    do_clr(1);
    for (int n = 0; n < 5; n++) draw(1, 0, 1, 4'd11 + 4'(n % 3));
    draw(1, 0, 1, 4'd13);

    // LUT keeps answering 0: four pips then err; clear wipes it.
    do_clr(0);
    draw(0, 1, 0, 4'd0);
    draw(1, 1, 0, 4'd15);
    do_clr(0);
    do_clr(1);

    // Clear while waiting on a latency-3 LUT: draw abandoned, late card ignored.
    @(negedge clk); num_i[1] = 4'd9; rp_i[1] = 1'b1;
    p0 = pipcnt[1]; g0 = gntcnt[1];
    @(negedge clk); chk("wait_busy", busy_o[1], 1);
    @(negedge clk); clr_i[1] = 1'b1; rp_i[1] = 1'b0;
    @(negedge clk); clr_i[1] = 1'b0;
    chk("clr_idle", busy_o[1], 0);
    repeat (6) @(negedge clk);
    chk("clr_gnt", gntcnt[1] - g0, 0);
    chk("clr_pips", pipcnt[1] - p0, 1);
    check_hands(1);

    // Random draws against the model.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 2; i++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0 || (!can_draw(i, 0) && !can_draw(i, 1) && r < 5)) begin
          do_clr(i);
        end else begin
          rp = 1'($urandom_range(0, 1));
          rd = 1'($urandom_range(0, 1));
          if (!rp && !rd) rp = 1'b1;
          if ($urandom_range(0, 19) < 18) v = 4'($urandom_range(1, 13));
          else if ($urandom_range(0, 1) == 0) v = 4'd0;
          else v = 4'($urandom_range(14, 15));
          draw(i, rp, rd, v);
        end
      end
    end

    chk("pip_gap_a", dblpip[0], 0);
    chk("pip_gap_b", dblpip[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
